// File: rtl/cpu.sv
// Single-cycle 32-bit MIPS-subset core with a 32x32 register file and a 256-word unified memory.
// Optional feature: define CPU_JUMP_EN to implement the j (opcode 0x02) instruction.
module cpu (
    input  logic        clk_cpu,
    input  logic        reset,
    input  logic [4:0]  reg_dbg_adrs,
    output logic [31:0] reg_dbg_q,
    output logic [31:0] pc
);

    localparam int unsigned XLEN      = 32;
    localparam int unsigned MEM_DEPTH = 256;
    localparam int unsigned NREGS     = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
`ifdef CPU_JUMP_EN
    localparam logic [5:0] OP_J     = 6'h02;
`endif

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    logic [XLEN-1:0] mem    [0:MEM_DEPTH-1];
    logic [XLEN-1:0] regs_q [0:NREGS-1];

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr;
    logic [5:0]      op, funct;
    logic [4:0]      rs, rt, rd;
    logic [XLEN-1:0] rs_val, rt_val, imm_sext, pc_plus4, ea;
    logic [XLEN-1:0] alu_res;
    logic            alu_valid;
    logic            rf_we;
    logic [4:0]      rf_wa;
    logic [XLEN-1:0] rf_wd;
    logic            mem_we;
    logic            unused_ea;

    assign instr    = mem[pc_q[9:2]];
    assign op       = instr[31:26];
    assign rs       = instr[25:21];
    assign rt       = instr[20:16];
    assign rd       = instr[15:11];
    assign funct    = instr[5:0];
    assign imm_sext = {{16{instr[15]}}, instr[15:0]};

    // r0 is forced to zero at the read side so it is valid even before the first reset
    assign rs_val    = (rs == 5'd0) ? '0 : regs_q[rs];
    assign rt_val    = (rt == 5'd0) ? '0 : regs_q[rt];
    assign reg_dbg_q = (reg_dbg_adrs == 5'd0) ? '0 : regs_q[reg_dbg_adrs];

    assign pc_plus4  = pc_q + XLEN'(4);
    assign ea        = rs_val + imm_sext;
    assign unused_ea = ^{ea[31:10], ea[1:0]};
    assign pc        = pc_q;

    // R-type ALU; unknown funct codes are flagged so they write nothing
    always_comb begin
        alu_res   = '0;
        alu_valid = 1'b1;
        case (funct)
            FN_ADD:  alu_res = rs_val + rt_val;
            FN_SUB:  alu_res = rs_val - rt_val;
            FN_AND:  alu_res = rs_val & rt_val;
            FN_OR:   alu_res = rs_val | rt_val;
            FN_SLT:  alu_res = {31'b0, $signed(rs_val) < $signed(rt_val)};
            default: alu_valid = 1'b0;
        endcase
    end

    // Decode: next pc and write-back controls
    always_comb begin
        pc_d   = pc_plus4;
        rf_we  = 1'b0;
        rf_wa  = rt;
        rf_wd  = ea;
        mem_we = 1'b0;
        case (op)
            OP_RTYPE: begin
                rf_we = alu_valid;
                rf_wa = rd;
                rf_wd = alu_res;
            end
            OP_ADDI: rf_we = 1'b1;
            OP_LW: begin
                rf_we = 1'b1;
                rf_wd = mem[ea[9:2]];
            end
            OP_SW:   mem_we = 1'b1;
            OP_BEQ: begin
                if (rs_val == rt_val) begin
                    pc_d = pc_plus4 + {imm_sext[29:0], 2'b00};
                end
            end
`ifdef CPU_JUMP_EN
            OP_J:    pc_d = {pc_plus4[31:28], instr[25:0], 2'b00};
`endif
            default: ;
        endcase
    end

    // Architectural state; reset squashes the in-flight register write
    always_ff @(posedge clk_cpu) begin
        if (reset) begin
            pc_q <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            pc_q <= pc_d;
            if (rf_we && (rf_wa != 5'd0)) begin
                regs_q[rf_wa] <= rf_wd;
            end
        end
    end

    // Memory contents survive reset; stores are blocked while reset is high
    always_ff @(posedge clk_cpu) begin
        if (!reset && mem_we) begin
            mem[ea[9:2]] <= rt_val;
        end
    end

endmodule

// File: tb/tb_cpu.sv
// Self-checking bench for cpu: directed program checks plus random programs against a reference model.
module tb_cpu;

    logic        clk_cpu = 1'b0;
    logic        reset;
    logic [4:0]  reg_dbg_adrs;
    logic [31:0] reg_dbg_q;
    logic [31:0] pc;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_mem  [256];
    logic [31:0] m_regs [32];
    logic [31:0] m_pc;

    cpu dut (
        .clk_cpu      (clk_cpu),
        .reset        (reset),
        .reg_dbg_adrs (reg_dbg_adrs),
        .reg_dbg_q    (reg_dbg_q),
        .pc           (pc)
    );

    always #50 clk_cpu = ~clk_cpu;

    function automatic logic [31:0] enc_r(input logic [5:0] fn, input int rs, input int rt, input int rd);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_j(input int target);
        return {6'h02, 26'(target)};
    endfunction

    // Reference model: one instruction, straight from the ISA description
    function automatic void model_step();
        logic [31:0] ins, a, b, sx, nxt, res;
        logic [5:0]  op, fn;
        int          rs, rt, rd, widx, wreg;
        logic        wr;
        ins  = m_mem[(m_pc % 1024) / 4];
        op   = ins[31:26];
        fn   = ins[5:0];
        rs   = int'(ins[25:21]);
        rt   = int'(ins[20:16]);
        rd   = int'(ins[15:11]);
        a    = m_regs[rs];
        b    = m_regs[rt];
        sx   = {{16{ins[15]}}, ins[15:0]};
        nxt  = m_pc + 4;
        wr   = 1'b0;
        wreg = 0;
        res  = 0;
        widx = int'(((a + sx) % 1024) / 4);
        case (op)
            6'h00: begin
                wreg = rd;
                wr   = 1'b1;
                case (fn)
                    6'h20:   res = a + b;
                    6'h22:   res = a - b;
                    6'h24:   res = a & b;
                    6'h25:   res = a | b;
                    6'h2A:   res = ($signed(a) < $signed(b)) ? 1 : 0;
                    default: wr = 1'b0;
                endcase
            end
            6'h08: begin wr = 1'b1; wreg = rt; res = a + sx; end
            6'h23: begin wr = 1'b1; wreg = rt; res = m_mem[widx]; end
            6'h2B: m_mem[widx] = b;
            6'h04: if (a == b) nxt = m_pc + 4 + sx * 4;
`ifdef CPU_JUMP_EN
            6'h02: nxt = ((m_pc + 4) & 32'hF000_0000) | (32'(ins[25:0]) * 4);
`endif
            default: ;
        endcase
        if (wr && wreg != 0) m_regs[wreg] = res;
        m_pc = nxt;
    endfunction

    task automatic sync_mem();
        for (int i = 0; i < 256; i++) dut.mem[i] = m_mem[i];
    endtask

    task automatic read_reg(input int idx, output logic [31:0] v);
        reg_dbg_adrs = 5'(idx);
        #1;
        v = reg_dbg_q;
    endtask

    // Hold reset for one edge so memory can be reloaded safely
    task automatic begin_test();
        @(negedge clk_cpu);
        reset = 1'b1;
        @(posedge clk_cpu);
        @(negedge clk_cpu);
        for (int i = 0; i < 256; i++) m_mem[i] = 32'h0;
    endtask

    task automatic release_reset();
        sync_mem();
        reset = 1'b0;
        m_pc  = 0;
        for (int i = 0; i < 32; i++) m_regs[i] = 0;
    endtask

    task automatic step();
        @(posedge clk_cpu);
        model_step();
        @(negedge clk_cpu);
    endtask

    task automatic test_reset();
        logic [31:0] v;
        for (int i = 0; i < 256; i++) m_mem[i] = $urandom;
        sync_mem();
        reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk_cpu);
            @(negedge clk_cpu);
            checks++;
            if (pc !== 32'h0) begin
                failures++;
                $display("FAIL reset_pc cycle %0d: got %h expected 00000000", c, pc);
            end
        end
        for (int r = 0; r < 32; r++) begin
            read_reg(r, v);
            checks++;
            if (v !== 32'h0) begin
                failures++;
                $display("FAIL reset_reg r%0d: got %h expected 00000000", r, v);
            end
        end
    endtask

    task automatic test_alu();
        logic [31:0] v;
        begin_test();
        m_mem[0] = enc_i(6'h08, 0, 1, 5);
        m_mem[1] = enc_i(6'h08, 0, 2, -3);
        m_mem[2] = enc_r(6'h20, 1, 2, 3);
        m_mem[3] = enc_r(6'h22, 2, 1, 4);
        m_mem[4] = enc_r(6'h2A, 2, 1, 5);
        release_reset();
        repeat (5) step();
        read_reg(3, v);
        checks++;
        if (v !== 32'h2) begin failures++; $display("FAIL alu_add r3: got %h expected 00000002", v); end
        read_reg(4, v);
        checks++;
        if (v !== 32'hFFFF_FFF8) begin failures++; $display("FAIL alu_sub r4: got %h expected fffffff8", v); end
        read_reg(5, v);
        checks++;
        if (v !== 32'h1) begin failures++; $display("FAIL alu_slt r5: got %h expected 00000001", v); end
        checks++;
        if (pc !== 32'd20) begin failures++; $display("FAIL alu_pc: got %h expected 00000014", pc); end
    endtask

    task automatic test_r0_wrap();
        logic [31:0] v;
        begin_test();
        m_mem[0] = enc_i(6'h08, 0, 0, 7);
        m_mem[1] = enc_i(6'h08, 0, 1, -1);
        m_mem[2] = enc_i(6'h08, 1, 1, 1);
        release_reset();
        step();
        read_reg(0, v);
        checks++;
        if (v !== 32'h0) begin failures++; $display("FAIL r0_write: got %h expected 00000000", v); end
        step();
        read_reg(1, v);
        checks++;
        if (v !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap_minus1: got %h expected ffffffff", v); end
        step();
        read_reg(1, v);
        checks++;
        if (v !== 32'h0) begin failures++; $display("FAIL wrap_zero: got %h expected 00000000", v); end
    endtask

    task automatic test_memory();
        logic [31:0] v;
        begin_test();
        m_mem[0] = enc_i(6'h08, 0, 1, 32'h55);
        m_mem[1] = enc_i(6'h2B, 0, 1, 32'h200);
        m_mem[2] = enc_i(6'h23, 0, 2, 32'h200);
        m_mem[3] = enc_i(6'h23, 0, 3, 32'h600);
        release_reset();
        repeat (4) step();
        checks++;
        if (dut.mem[128] !== 32'h55) begin failures++; $display("FAIL mem_sw: got %h expected 00000055", dut.mem[128]); end
        read_reg(2, v);
        checks++;
        if (v !== 32'h55) begin failures++; $display("FAIL mem_lw r2: got %h expected 00000055", v); end
        read_reg(3, v);
        checks++;
        if (v !== 32'h55) begin failures++; $display("FAIL mem_alias r3: got %h expected 00000055", v); end
    endtask

    task automatic test_branch();
        begin_test();
        m_mem[0] = enc_i(6'h04, 0, 0, 2);
        m_mem[3] = enc_i(6'h08, 0, 1, 1);
        m_mem[4] = enc_i(6'h04, 0, 1, 5);
        release_reset();
        step();
        checks++;
        if (pc !== 32'd12) begin failures++; $display("FAIL beq_taken: got %h expected 0000000c", pc); end
        step();
        step();
        checks++;
        if (pc !== 32'd20) begin failures++; $display("FAIL beq_not_taken: got %h expected 00000014", pc); end
    endtask

    task automatic test_jump_reset();
        logic [31:0] exp_pc;
        logic [31:0] v;
        begin_test();
        m_mem[0]   = enc_j(32'h10);
        m_mem[1]   = enc_i(6'h08, 0, 1, 9);
        m_mem[2]   = enc_i(6'h2B, 0, 1, 32'h300);
        m_mem[16]  = enc_i(6'h08, 0, 1, 9);
        m_mem[17]  = enc_i(6'h2B, 0, 1, 32'h300);
        m_mem[192] = 32'hDEAD_BEEF;
`ifdef CPU_JUMP_EN
        exp_pc = 32'h40;
`else
        exp_pc = 32'h4;
`endif
        release_reset();
        step();
        checks++;
        if (pc !== exp_pc) begin failures++; $display("FAIL jump_pc: got %h expected %h", pc, exp_pc); end
        step();
        // Reset lands on the store: it must be squashed
        reset = 1'b1;
        @(posedge clk_cpu);
        @(negedge clk_cpu);
        checks++;
        if (pc !== 32'h0) begin failures++; $display("FAIL midreset_pc: got %h expected 00000000", pc); end
        checks++;
        if (dut.mem[192] !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL midreset_store: got %h expected deadbeef", dut.mem[192]);
        end
        read_reg(1, v);
        checks++;
        if (v !== 32'h0) begin failures++; $display("FAIL midreset_reg: got %h expected 00000000", v); end
        reset = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] fns [6];
        int         kind;
        fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24;
        fns[3] = 6'h25; fns[4] = 6'h2A; fns[5] = 6'($urandom);
        kind = int'($urandom_range(0, 9));
        case (kind)
            0, 1, 2: return enc_r(fns[$urandom_range(0, 5)], $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            3, 4:    return enc_i(6'h08, $urandom_range(0, 7), $urandom_range(0, 7), $urandom);
            5:       return enc_i(6'h23, $urandom_range(0, 7), $urandom_range(0, 7), $urandom);
            6:       return enc_i(6'h2B, $urandom_range(0, 7), $urandom_range(0, 7), $urandom);
            7:       return enc_i(6'h04, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 6) - 3);
            8:       return enc_j($urandom_range(0, 60));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        logic [31:0] v;
        for (int p = 0; p < 4; p++) begin
            begin_test();
            for (int i = 0; i < 256; i++) m_mem[i] = $urandom;
            for (int i = 0; i < 40; i++) m_mem[i] = rand_instr();
            release_reset();
            for (int c = 0; c < 60; c++) begin
                step();
                checks++;
                if (pc !== m_pc) begin
                    failures++;
                    $display("FAIL rand_pc prog %0d cycle %0d: got %h expected %h", p, c, pc, m_pc);
                end
                for (int r = 0; r < 32; r++) begin
                    read_reg(r, v);
                    checks++;
                    if (v !== m_regs[r]) begin
                        failures++;
                        $display("FAIL rand_reg prog %0d cycle %0d r%0d: got %h expected %h", p, c, r, v, m_regs[r]);
                    end
                end
            end
            for (int i = 0; i < 256; i++) begin
                checks++;
                if (dut.mem[i] !== m_mem[i]) begin
                    failures++;
                    $display("FAIL rand_mem prog %0d word %0d: got %h expected %h", p, i, dut.mem[i], m_mem[i]);
                end
            end
        end
    endtask

    initial begin
        reset        = 1'b1;
        reg_dbg_adrs = 5'd0;
        test_reset();
        test_alu();
        test_r0_wrap();
        test_memory();
        test_branch();
        test_jump_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
